dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Parametrised data-memory controller for the LEGv8 datapath. It replaces the flat 64-bit single-cycle array with a request/response memory stage. The stage supports byte, half, word and doubleword accesses with sign/zero extension, a configurable wait-state count, alignment and range fault detection, and a hardware zero-fill after reset. It sits between the EX/MEM pipeline register and the MEM/WB writeback mux.

## Interface
- DEPTH, 256, number of 64-bit doublewords; power of two, ≥ 4
- BASE_ADDR, 64'h0, byte address of doubleword 0
- WAIT_CYCLES, 1, extra cycles between accept and response; 0–15
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- REQ  in  1  access request; sampled only when READY=1
- WE  in  1  1 = store, 0 = load
- SIZE  in  2  0 byte, 1 half, 2 word, 3 doubleword
- SIGNED  in  1  load sign-extends when 1 (LDURSW etc.); ignored for stores and SIZE=3
- ADDR  in  64  byte address
- WR_DATA  in  64  store data, right-justified (low SIZE bytes used)
- READY  out  1  controller can accept a request this cycle
- RESP_VALID  out  1  one-cycle pulse: access complete
- RD_DATA  out  64  extended load data; valid only with RESP_VALID on a load
- FAULT  out  1  qualifies RESP_VALID: access rejected, no memory effect

## Operation
- FSM states: INIT → IDLE → WAIT → RESP → IDLE.
- INIT (entered on reset):
  - Writes zero to index 0..DEPTH-1, one index per cycle.
  - READY=0 throughout; moves to IDLE after index DEPTH-1.
- IDLE:
  - READY=1.
  - On REQ, latch WE/SIZE/SIGNED/ADDR/WR_DATA.
  - Go to WAIT if WAIT_CYCLES>0, else go to RESP.
- WAIT:
  - Counter loads WAIT_CYCLES-1 on accept and decrements each cycle.
  - Go to RESP when the counter reaches 0.
- RESP:
  - RESP_VALID=1 and READY=0.
  - Return to IDLE next cycle. No back-to-back accept in RESP.
- Address decode:
  - off = ADDR − BASE_ADDR, 64-bit unsigned.
  - idx = off[3+clog2(DEPTH)-1:3].
  - lane = off[2:0].
- Fault conditions:
  - off ≥ DEPTH×8, i.e. out of range (includes ADDR < BASE_ADDR through wrap).
  - lane not a multiple of 2^SIZE, i.e. misaligned.
- On fault:
  - Store is suppressed.
  - RD_DATA = 0.
  - FAULT=1 with RESP_VALID.
- Stores: byte-enable mask = ((1<<2^SIZE)−1) << lane. Only the enabled bytes of idx are written. Little-endian.
- Store commit: the write is performed in the RESP cycle.
- Loads:
  - Read idx, shift right by lane×8, mask to 2^SIZE bytes.
  - Sign-extend from the top bit of that field when SIGNED, else zero-extend.
- Read-after-write: a load accepted after a store's RESP returns the new data.
- REQ while READY=0 is ignored; the requester must hold REQ until it sees READY.
- Inputs are don't-care after the accept edge.

## Timing
- Reset values:
  - READY=0, RESP_VALID=0, FAULT=0, RD_DATA=0.
  - State INIT, init counter 0, wait counter 0.
- Reset zero-fill takes DEPTH cycles; READY rises in the cycle after the last fill write.
- Latency: request accepted at edge T → RESP_VALID high during cycle T+1+WAIT_CYCLES.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- RD_DATA and FAULT are registered. They change only on the edge entering RESP and clear to 0 on leaving it.
- RST_N asserted mid-access:
  - Immediate abort; no partial store completes.
  - Outputs take their reset values and INIT restarts.
- Memory array: synchronous write, synchronous read with one-cycle read latency, inferable as block RAM. The read is issued on entering the last WAIT cycle, or at accept when WAIT_CYCLES=0.

## Structure
- Package dmem_pkg:
  - size_e enum (SZ_B, SZ_H, SZ_W, SZ_D).
  - state_e enum (INIT, IDLE, WAIT, RESP).
  - Byte-mask and extend helper functions.
- Sub-module dmem_array:
  - Single-port DEPTH×64 RAM with 8-bit byte-enable and registered read, no reset.
  - INIT drives its port through the same write path with mask 8'hFF and data 0.

## Test plan
- Reset fill: DEPTH=8, release RST_N → READY low 8 cycles; afterwards doubleword load at BASE_ADDR+0x38 returns 0.
- Store/load sizes:
  - STUR 64'h8877665544332211 at 0x10, then LDURB 0x13 → 0x44.
  - LDURH signed at 0x16 → 0x...0000_8877 zero-extended, sign-extended to 64'hFFFF_FFFF_FFFF_8877.
- Partial store: after the above, STURB 0xAB at 0x11, then LDUR 0x10 → 64'h887766554433AB11.
- Faults:
  - Word load at 0x12 → FAULT=1, RD_DATA=0.
  - Store to BASE_ADDR+DEPTH×8 → FAULT=1, and a subsequent load of the last doubleword is unchanged.
- Latency sweep: WAIT_CYCLES=0 and 3 → RESP_VALID exactly 1 and 4 cycles after accept; REQ held during RESP is not accepted until IDLE.
- Reset mid-access: assert RST_N during WAIT of a store to 0x20 → outputs 0, INIT reruns, and a later load of 0x20 returns 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller: access size and
// FSM state encodings, plus byte-lane mask, alignment and load-extension helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    // Byte enables for an access of 2^size bytes starting at byte lane 'lane'
    function automatic logic [7:0] byte_mask(size_e size, logic [2:0] lane);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << lane;
    endfunction

    // True when the lane is not a multiple of the access size
    function automatic logic misaligned(size_e size, logic [2:0] lane);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lane[0];
            SZ_W:    bad = |lane[1:0];
            default: bad = |lane;
        endcase
        return bad;
    endfunction

    // Keep the low 2^size bytes of a right-justified field and extend to 64 bits
    function automatic logic [63:0] extend_load(logic [63:0] raw, size_e size, logic sgn);
        logic [63:0] r;
        case (size)
            SZ_B:    r = sgn ? {{56{raw[7]}},  raw[7:0]}  : {56'd0, raw[7:0]};
            SZ_H:    r = sgn ? {{48{raw[15]}}, raw[15:0]} : {48'd0, raw[15:0]};
            SZ_W:    r = sgn ? {{32{raw[31]}}, raw[31:0]} : {32'd0, raw[31:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the EX/MEM register and the memory stage.
interface dmem_if;
    import dmem_pkg::*;

    logic        REQ;
    logic        WE;
    size_e       SIZE;
    logic        SIGNED;
    logic [63:0] ADDR;
    logic [63:0] WR_DATA;
    logic        READY;
    logic        RESP_VALID;
    logic [63:0] RD_DATA;
    logic        FAULT;

    modport master (
        output REQ, WE, SIZE, SIGNED, ADDR, WR_DATA,
        input  READY, RESP_VALID, RD_DATA, FAULT
    );

    modport slave (
        input  REQ, WE, SIZE, SIGNED, ADDR, WR_DATA,
        output READY, RESP_VALID, RD_DATA, FAULT
    );
endinterface

// File: rtl/dmem_array.sv
// Single-port DEPTH x 64 RAM with per-byte write enables and a registered read.
// No reset on the storage or the read register so it maps onto block RAM.
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic [AW-1:0] idx,
    input  logic          we,
    input  logic [7:0]    mask,
    input  logic [63:0]   wdata,
    input  logic          re,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH];

    // Byte-masked write and one-cycle registered read on the same port
    always_ff @(posedge CLK) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (mask[b]) begin
                    mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// LEGv8 data-memory stage: zero-fills the RAM after reset, then serves one
// byte/half/word/doubleword access at a time with a fixed wait-state count,
// rejecting out-of-range and misaligned accesses with FAULT.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic   CLK,
    input  logic   RST_N,
    dmem_if.slave  bus
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [63:0] SPAN      = 64'(DEPTH) * 64'd8;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e        state_reg, state_next;
    logic [AW-1:0] init_cnt_reg;
    logic [3:0]    wait_cnt_reg;
    logic          we_reg;
    size_e         size_reg;
    logic          sgn_reg;
    logic [63:0]   off_reg;
    logic [63:0]   wdata_reg;
    logic          fault_reg;

    logic          ready;
    logic          resp_valid;
    logic          accept;
    logic [63:0]   bus_off;
    logic          bus_fault;
    logic          lat_fault;

    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_idx;
    logic [7:0]    ram_mask;
    logic [63:0]   ram_wdata;
    logic [63:0]   ram_rdata;

    // Offsets wrap, so an address below BASE_ADDR lands far out of range
    assign bus_off   = bus.ADDR - BASE_ADDR;
    assign bus_fault = (bus_off >= SPAN) || misaligned(bus.SIZE, bus_off[2:0]);
    assign lat_fault = (off_reg >= SPAN) || misaligned(size_reg, off_reg[2:0]);
    assign accept    = (state_reg == IDLE) && bus.REQ;

    // Next-state and handshake outputs
    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        resp_valid = 1'b0;
        case (state_reg)
            INIT: begin
                if (init_cnt_reg == AW'(DEPTH - 1)) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                ready = 1'b1;
                if (bus.REQ) begin
                    state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (wait_cnt_reg == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = INIT;
        endcase
    end

    // RAM port steering: fill writes in INIT, read in the cycle before RESP,
    // committed store in RESP. In IDLE the index comes straight off the bus so a
    // zero-wait access can issue its read on the accept edge.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_idx   = off_reg[AW+2:3];
        ram_mask  = 8'h00;
        ram_wdata = 64'd0;
        case (state_reg)
            INIT: begin
                ram_we   = 1'b1;
                ram_idx  = init_cnt_reg;
                ram_mask = 8'hFF;
            end
            IDLE: begin
                ram_idx = bus_off[AW+2:3];
                ram_re  = bus.REQ && (WAIT_CYCLES == 0);
            end
            WAIT: begin
                ram_re = (wait_cnt_reg == 4'd0);
            end
            RESP: begin
                if (we_reg && !fault_reg) begin
                    ram_we    = 1'b1;
                    ram_mask  = byte_mask(size_reg, off_reg[2:0]);
                    ram_wdata = wdata_reg << {off_reg[2:0], 3'b000};
                end
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Zero-fill index and wait-state down-counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            init_cnt_reg <= '0;
            wait_cnt_reg <= 4'd0;
        end else begin
            if (state_reg == INIT) begin
                init_cnt_reg <= init_cnt_reg + AW'(1);
            end
            if (accept) begin
                wait_cnt_reg <= WAIT_LOAD;
            end else if (state_reg == WAIT && wait_cnt_reg != 4'd0) begin
                wait_cnt_reg <= wait_cnt_reg - 4'd1;
            end
        end
    end

    // Capture the request on accept; the requester may change inputs afterwards
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            we_reg    <= 1'b0;
            size_reg  <= SZ_B;
            sgn_reg   <= 1'b0;
            off_reg   <= 64'd0;
            wdata_reg <= 64'd0;
        end else if (accept) begin
            we_reg    <= bus.WE;
            size_reg  <= bus.SIZE;
            sgn_reg   <= bus.SIGNED;
            off_reg   <= bus_off;
            wdata_reg <= bus.WR_DATA;
        end
    end

    // FAULT is loaded on the edge entering RESP and cleared on leaving it
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fault_reg <= 1'b0;
        end else if (state_reg == RESP) begin
            fault_reg <= 1'b0;
        end else if (state_next == RESP) begin
            fault_reg <= (state_reg == IDLE) ? bus_fault : lat_fault;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .CLK   (CLK),
        .idx   (ram_idx),
        .we    (ram_we),
        .mask  (ram_mask),
        .wdata (ram_wdata),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    assign bus.READY      = ready;
    assign bus.RESP_VALID = resp_valid;
    assign bus.FAULT      = fault_reg;
    // Load data comes from the RAM output register, lane-shifted and extended;
    // forced to zero outside RESP, on stores and on faults.
    assign bus.RD_DATA    = (state_reg == RESP && !we_reg && !fault_reg)
                          ? extend_load(ram_rdata >> {off_reg[2:0], 3'b000}, size_reg, sgn_reg)
                          : 64'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Drives two controllers (zero and three wait states) with the same access
// stream and compares both against a byte-addressed memory model.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int          DEPTH = 8;
    localparam int          SPAN  = DEPTH * 8;
    localparam logic [63:0] BASE  = 64'h1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   txn_no = 0;
    logic [7:0] model_mem [SPAN];

    dmem_if bus0();
    dmem_if bus3();

    dmem_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
        .CLK(clk), .RST_N(rst_n), .bus(bus0)
    );
    dmem_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut3 (
        .CLK(clk), .RST_N(rst_n), .bus(bus3)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [63:0] addr, input logic [63:0] wd);
        bus0.REQ = req; bus0.WE = we; bus0.SIZE = size_e'(sz); bus0.SIGNED = sg;
        bus0.ADDR = addr; bus0.WR_DATA = wd;
        bus3.REQ = req; bus3.WE = we; bus3.SIZE = size_e'(sz); bus3.SIGNED = sg;
        bus3.ADDR = addr; bus3.WR_DATA = wd;
    endtask

    task automatic model_clear();
        for (int i = 0; i < SPAN; i++) model_mem[i] = 8'h00;
    endtask

    // Reference: byte-addressed little-endian memory
    task automatic model_access(input logic we, input logic [1:0] sz, input logic sg,
                                input logic [63:0] addr, input logic [63:0] wd,
                                output logic flt, output logic [63:0] rd);
        logic [63:0] off;
        int nb;
        off = addr - BASE;
        nb  = 1 << sz;
        rd  = 64'd0;
        flt = (off >= 64'(SPAN)) || ((off % 64'(nb)) != 64'd0);
        if (!flt) begin
            if (we) begin
                for (int i = 0; i < nb; i++) model_mem[int'(off) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) rd = rd | (64'(model_mem[int'(off) + i]) << (8*i));
                if (sg && nb < 8 && rd[8*nb-1]) rd = rd | (~64'd0 << (8*nb));
            end
        end
    endtask

    task automatic wait_ready();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus0.READY && bus3.READY) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("ready_wait", 64'(ok), 64'd1);
    endtask

    task automatic check_reset_outputs();
        check_val("rst_ready_w0", 64'(bus0.READY), 64'd0);
        check_val("rst_valid_w0", 64'(bus0.RESP_VALID), 64'd0);
        check_val("rst_fault_w0", 64'(bus0.FAULT), 64'd0);
        check_val("rst_rddata_w0", bus0.RD_DATA, 64'd0);
        check_val("rst_ready_w3", 64'(bus3.READY), 64'd0);
        check_val("rst_valid_w3", 64'(bus3.RESP_VALID), 64'd0);
        check_val("rst_fault_w3", 64'(bus3.FAULT), 64'd0);
        check_val("rst_rddata_w3", bus3.RD_DATA, 64'd0);
    endtask

    // Called at the negedge where RST_N is released; READY must first be seen
    // high DEPTH cycles later
    task automatic measure_init();
        int c0, c3;
        c0 = 0; c3 = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (c0 == 0 && bus0.READY) c0 = n;
            if (c3 == 0 && bus3.READY) c3 = n;
            if (c0 != 0 && c3 != 0) break;
        end
        check_val("init_len_w0", 64'(c0), 64'(DEPTH));
        check_val("init_len_w3", 64'(c3), 64'(DEPTH));
        $display("init fill: ready after %0d/%0d cycles", c0, c3);
    endtask

    // One access on both controllers; offset is relative to BASE
    task automatic access(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [63:0] off, input logic [63:0] wd,
                          output logic [63:0] rd_o, output logic flt_o);
        logic [63:0] addr, exp_rd, rd0, rd3;
        logic exp_flt, f0, f3;
        int lat0, lat3, p0, p3;
        addr = BASE + off;
        model_access(we, sz, sg, addr, wd, exp_flt, exp_rd);
        wait_ready();
        drive(1'b1, we, sz, sg, addr, wd);
        @(posedge clk);
        #1;
        drive(1'b0, ~we, ~sz, ~sg, ~addr, ~wd);
        lat0 = 0; lat3 = 0; p0 = 0; p3 = 0;
        rd0 = 64'd0; rd3 = 64'd0; f0 = 1'b0; f3 = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (bus0.RESP_VALID) begin
                p0++;
                if (lat0 == 0) begin lat0 = n; rd0 = bus0.RD_DATA; f0 = bus0.FAULT; end
            end
            if (bus3.RESP_VALID) begin
                p3++;
                if (lat3 == 0) begin lat3 = n; rd3 = bus3.RD_DATA; f3 = bus3.FAULT; end
            end
        end
        txn_no++;
        $display("txn %0d %s size=%0d signed=%0d addr=%h wdata=%h rd=%h/%h fault=%0d/%0d lat=%0d/%0d",
                 txn_no, we ? "st" : "ld", sz, sg, addr, wd, rd0, rd3, f0, f3, lat0, lat3);
        check_val("latency_w0", 64'(lat0), 64'd1);
        check_val("latency_w3", 64'(lat3), 64'd4);
        check_val("pulses_w0", 64'(p0), 64'd1);
        check_val("pulses_w3", 64'(p3), 64'd1);
        check_val("fault_w0", 64'(f0), 64'(exp_flt));
        check_val("fault_w3", 64'(f3), 64'(exp_flt));
        if (!we) begin
            check_val("rd_w0", rd0, exp_rd);
            check_val("rd_w3", rd3, exp_rd);
        end
        rd_o  = rd0;
        flt_o = f0;
    endtask

    logic [63:0] rd, off_r, wd_r;
    logic        flt, we_r, sg_r;
    logic [1:0]  sz_r;
    logic [15:0] mask0, mask3, exp0, exp3;
    int          pick;

    initial begin
        drive(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
        model_clear();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        measure_init();

        // Zero fill, sized stores/loads, partial store
        access(1'b0, 2'd3, 1'b0, 64'h38, 64'd0, rd, flt);
        check_val("fill_ld_0x38", rd, 64'd0);
        access(1'b1, 2'd3, 1'b0, 64'h10, 64'h8877665544332211, rd, flt);
        access(1'b0, 2'd0, 1'b0, 64'h13, 64'd0, rd, flt);
        check_val("ldurb_0x13", rd, 64'h44);
        access(1'b0, 2'd1, 1'b0, 64'h16, 64'd0, rd, flt);
        check_val("ldurh_u_0x16", rd, 64'h8877);
        access(1'b0, 2'd1, 1'b1, 64'h16, 64'd0, rd, flt);
        check_val("ldurh_s_0x16", rd, 64'hFFFF_FFFF_FFFF_8877);
        access(1'b1, 2'd0, 1'b0, 64'h11, 64'hDEAD_BEEF_CAFE_12AB, rd, flt);
        access(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, rd, flt);
        check_val("ldur_0x10_after_sturb", rd, 64'h8877_6655_4433_AB11);

        // Faults: misaligned, out of range, below base
        access(1'b0, 2'd2, 1'b0, 64'h12, 64'd0, rd, flt);
        check_val("ldurw_0x12_fault", 64'(flt), 64'd1);
        check_val("ldurw_0x12_rd", rd, 64'd0);
        access(1'b1, 2'd3, 1'b0, 64'h38, 64'h1122_3344_5566_7788, rd, flt);
        access(1'b1, 2'd3, 1'b0, 64'(SPAN), 64'hFFFF_0000_FFFF_0000, rd, flt);
        check_val("stur_oor_fault", 64'(flt), 64'd1);
        access(1'b0, 2'd3, 1'b0, 64'h38, 64'd0, rd, flt);
        check_val("last_dw_unchanged", rd, 64'h1122_3344_5566_7788);
        access(1'b1, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h5A5A, rd, flt);
        check_val("stur_below_base_fault", 64'(flt), 64'd1);

        // REQ held continuously: a new accept only happens from IDLE, so
        // responses repeat every WAIT_CYCLES+2 cycles
        wait_ready();
        drive(1'b1, 1'b0, 2'd3, 1'b0, BASE + 64'h10, 64'd0);
        mask0 = 16'd0; mask3 = 16'd0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (bus0.RESP_VALID) mask0[n] = 1'b1;
            if (bus3.RESP_VALID) mask3[n] = 1'b1;
        end
        drive(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
        exp0 = 16'd0; exp3 = 16'd0;
        for (int p = 1; p <= 14; p += 2) exp0[p] = 1'b1;
        for (int p = 4; p <= 14; p += 5) exp3[p] = 1'b1;
        $display("hold-req: pulse map %h/%h", mask0, mask3);
        check_val("hold_pulses_w0", 64'(mask0), 64'(exp0));
        check_val("hold_pulses_w3", 64'(mask3), 64'(exp3));

        // Randomized accesses, mostly in range, some aligned on purpose
        for (int t = 0; t < 120; t++) begin
            we_r = 1'($urandom_range(0, 1));
            sz_r = 2'($urandom_range(0, 3));
            sg_r = 1'($urandom_range(0, 1));
            pick = int'($urandom_range(0, 9));
            if (pick == 0) begin
                off_r = 64'(SPAN) + 64'($urandom_range(0, 15));
            end else if (pick == 1) begin
                off_r = 64'd0 - 64'($urandom_range(1, 16));
            end else begin
                off_r = 64'($urandom_range(0, SPAN - 1));
                if (pick < 7) off_r = off_r & ~64'((1 << sz_r) - 1);
            end
            wd_r = {$urandom, $urandom};
            access(we_r, sz_r, sg_r, off_r, wd_r, rd, flt);
        end

        // Reset during the wait phase of a store to 0x20
        wait_ready();
        drive(1'b1, 1'b1, 2'd3, 1'b0, BASE + 64'h20, 64'h0123_4567_89AB_CDEF);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        measure_init();
        access(1'b0, 2'd3, 1'b0, 64'h20, 64'd0, rd, flt);
        check_val("ld_0x20_after_reset", rd, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
